icache_refill: RTL and testbench
================================

# icache_refill

Line-refill engine for the instruction cache: the writer side of the icache data and tag RAMs. On a miss it issues one AXI read burst for the 32-byte line, writes each returned 32-bit word into the matching data-RAM bank at the line index, then writes the tag. It sits between the icache miss logic and the AXI read channels of the CPU bus interface. It forwards the missed word to the fetch stage.

## Interface
Parameters:
- `IDX_W`, 7, line index width (`addr[11:5]`, 128 sets).
- `ID_W`, 4, AXI ID width.
- `ARID_VAL`, 0, constant ARID driven on every request.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: miss request.
- `req_ready` out 1: high only in IDLE.
- `req_addr` in 32: missed fetch address.
- `arvalid`, `arready` out/in 1: AXI AR handshake.
- `araddr` out 32: burst start address.
- `arlen` out 8: burst length, fixed `8'd7`.
- `arsize` out 3: beat size, fixed `3'd2`.
- `arburst` out 2: burst type (see Configuration).
- `arid` out `ID_W`: burst ID, equal to `ARID_VAL`.
- `rvalid`, `rready` in/out 1: AXI R handshake.
- `rdata` in 32: beat data.
- `rresp` in 2: beat response.
- `rlast` in 1: last-beat flag.
- `ram_en` out 8: one-hot data-bank enable. Bank = word offset `addr[4:2]`.
- `ram_wen` out 8: one-hot data-bank write enable.
- `ram_addr` out `IDX_W`: latched `req_addr[11:5]`.
- `ram_wdata` out 32: equal to `rdata`.
- `tag_wen` out 1: one-cycle tag write strobe.
- `tag_wdata` out 21: `{valid, req_addr[31:12]}`.
- `fwd_valid` out 1: one-cycle pulse carrying the missed word.
- `fwd_data` out 32: the missed word.
- `done` out 1: one-cycle pulse when the refill is complete.
- `err` out 1: error flag; held until the next accepted request.

## Operation
- States are IDLE, AR, R and FIN.
- IDLE: `req_ready=1`. The request is accepted when `req_valid` is high. `req_addr` is latched and `err` is cleared. Next state is AR.
- AR: `arvalid=1` with stable AR fields until `arready`. Next state is R.
- R:
  - `rready=1`.
  - On each `rvalid`: `ram_en[b]=ram_wen[b]=1` in the same cycle, where `b` is the beat word index.
  - The 3-bit beat counter starts at 0 and increments per beat.
  - Word index = start offset + counter, modulo 8 (wrap-around).
  - After the 8th beat, next state is FIN.
- FIN:
  - `tag_wen=1` and `done=1` for exactly one cycle. Next state is IDLE.
  - Valid bit in `tag_wdata` is 1 unless `err` is set.
- Error handling:
  - `err` is set by any beat with `rresp != 2'b00`.
  - `err` is also set by an `rlast` mismatch: `rlast` high on beats 0–6, or low on beat 7.
  - The refill still completes all 8 beats; the line is left invalid.
- Reset, including mid-burst: state returns to IDLE and all outputs go to 0, except `req_ready=1`. Partially written RAM contents are don't-care because the tag was never written.

## Timing
- Accept → `arvalid` 1 cycle later.
- Each R beat → RAM write in the same cycle (combinational from `rvalid`).
- Beat 8 accepted → `tag_wen`/`done` on the next cycle → `req_ready` on the cycle after that.
- Minimum occupancy with zero-wait AXI: 1 (AR) + 8 (R) + 1 (FIN) = 10 cycles per line.
- `rvalid` bubbles stall the counter; there is no timeout.
- `req_valid` outside IDLE is ignored.

## Configuration
- `ICACHE_CRITICAL_WORD_FIRST_EN` defined:
  - `arburst=2'b10` (WRAP).
  - `araddr={req_addr[31:2],2'b00}`.
  - Start offset = `req_addr[4:2]`.
  - `fwd_valid` pulses on beat 0.
- `ICACHE_CRITICAL_WORD_FIRST_EN` undefined:
  - `arburst=2'b01` (INCR).
  - `araddr={req_addr[31:5],5'b0}`.
  - Start offset = 0.
  - `fwd_valid` pulses on the beat whose counter equals `req_addr[4:2]`.
- In both builds, `fwd_data` is the `rdata` of the pulsing beat, in the same cycle.

## Test plan
- `req_addr=32'h1FC0_0024`, zero-wait AXI, data `32'hA0..A7` → `ram_addr=7'h01`; all 8 banks written; `tag_wdata={1'b1,20'h1FC00}`; `done` at cycle 10.
  - With macro: `araddr=32'h1FC0_0024`; first write goes to bank 1; `fwd_data=32'hA0` on beat 0.
  - Without macro: `araddr=32'h1FC0_0020`; `fwd_data=32'hA1` on beat 1.
- `arready` held low for 5 cycles → `arvalid` and AR fields stable throughout; no RAM writes before `arready`.
- `rvalid` toggling 1-0-1-0 → exactly 8 single-bank writes; `done` only after the 8th beat.
- `rresp=2'b10` on beat 3 → `err=1`; `tag_wdata[20]=0`; `done` still pulses; `err` clears on the next accept.
- `rlast` asserted on beat 5 → `err=1`; state stays in R until 8 beats are received.
- `resetn` low mid-burst at beat 4 → `arvalid`, `rready`, `ram_wen`, `tag_wen` = 0 immediately; `req_ready=1` after release; the next request refills correctly.

Source files
------------

// File: rtl/icache_refill.sv
// icache_refill: line-refill engine for the instruction cache.
// It issues one 8-beat AXI read burst per missed 32-byte line and writes
// each returned word straight into its data-RAM bank. After the last beat
// it writes the tag, and it forwards the missed word to fetch on the way.
// Optional feature macro: ICACHE_CRITICAL_WORD_FIRST_EN. When it is defined,
// the burst is a WRAP burst that starts at the missed word. The default
// build uses an INCR burst that starts at the line base.
module icache_refill #(
    parameter int              IDX_W    = 7,
    parameter int              ID_W     = 4,
    parameter logic [ID_W-1:0] ARID_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             arvalid,
    input  logic             arready,
    output logic [31:0]      araddr,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic [ID_W-1:0]  arid,
    input  logic             rvalid,
    output logic             rready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    output logic [7:0]       ram_en,
    output logic [7:0]       ram_wen,
    output logic [IDX_W-1:0] ram_addr,
    output logic [31:0]      ram_wdata,
    output logic             tag_wen,
    output logic [20:0]      tag_wdata,
    output logic             fwd_valid,
    output logic [31:0]      fwd_data,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_FIN} state_e;

    state_e      state_q, state_d;
    logic [31:2] addr_q, addr_d;     // byte offset never matters for a word refill
    logic [2:0]  cnt_q, cnt_d;       // beat counter, 0..7
    logic        err_q, err_d;

    logic        beat;               // an R beat is accepted this cycle
    logic        last_beat;
    logic [2:0]  start_off;
    logic [2:0]  word_idx;
    logic        fwd_hit;
    logic [31:0] ar_addr_c;
    logic [1:0]  ar_burst_c;
    logic        unused_addr_bits;

    // The two low address bits are not needed anywhere in this block.
    assign unused_addr_bits = ^req_addr[1:0];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    // Critical word first: the burst wraps from the missed word, so beat 0 is the one to forward.
    assign ar_addr_c  = {addr_q[31:2], 2'b00};
    assign ar_burst_c = 2'b10;
    assign start_off  = addr_q[4:2];
    assign fwd_hit    = (cnt_q == 3'd0);
`else
    // Line-base order: the missed word shows up on the beat whose count equals its offset.
    assign ar_addr_c  = {addr_q[31:5], 5'b0};
    assign ar_burst_c = 2'b01;
    assign start_off  = 3'd0;
    assign fwd_hit    = (cnt_q == addr_q[4:2]);
`endif

    assign beat      = (state_q == S_R) && rvalid;
    assign last_beat = (cnt_q == 3'd7);
    assign word_idx  = start_off + cnt_q;   // 3-bit add wraps modulo 8

    // State register.
    // NOTE: sequential state is updated with <= so that every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Stalls wait for the handshakes, and there is no timeout.
    // NOTE: every comb output gets a default first so that no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_AR;
            S_AR:    if (arready) state_d = S_R;
            S_R:     if (beat && last_beat) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, beat counter and sticky error, next-state values.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (state_q == S_IDLE && req_valid) begin
            addr_d = req_addr[31:2];
            cnt_d  = 3'd0;
            err_d  = 1'b0;
        end else if (beat) begin
            cnt_d = cnt_q + 3'd1;
            // A bad response, or rlast out of place, poisons the line. The burst still completes.
            if (rresp != 2'b00 || rlast != last_beat) err_d = 1'b1;
        end
    end

    // Request latch, beat counter and sticky error registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Outputs. AR fields are driven only while arvalid is high, so that every output is 0 in reset.
    always_comb begin
        req_ready = 1'b0;
        arvalid   = 1'b0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arburst   = '0;
        arid      = '0;
        rready    = 1'b0;
        ram_en    = '0;
        ram_wen   = '0;
        ram_wdata = '0;
        tag_wen   = 1'b0;
        tag_wdata = '0;
        fwd_valid = 1'b0;
        fwd_data  = '0;
        done      = 1'b0;
        ram_addr  = addr_q[5 +: IDX_W];
        err       = err_q;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_AR: begin
                arvalid = 1'b1;
                araddr  = ar_addr_c;
                arlen   = 8'd7;
                arsize  = 3'd2;
                arburst = ar_burst_c;
                arid    = ARID_VAL;
            end
            S_R: begin
                rready    = 1'b1;
                ram_wdata = rdata;
                if (beat) begin
                    ram_en  = 8'b1 << word_idx;
                    ram_wen = 8'b1 << word_idx;
                    if (fwd_hit) begin
                        fwd_valid = 1'b1;
                        fwd_data  = rdata;
                    end
                end
            end
            S_FIN: begin
                tag_wen   = 1'b1;
                done      = 1'b1;
                tag_wdata = {~err_q, addr_q[31:12]};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_refill.sv
// Directed testbench for icache_refill. The bench models an AXI slave cycle
// by cycle and works out every expected bank, address and tag from the
// request address. The build macro ICACHE_CRITICAL_WORD_FIRST_EN selects the
// matching expectations.
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [7:0]  ram_en, ram_wen;
    logic [6:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        tag_wen;
    logic [20:0] tag_wdata;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        done, err;

    int n_checks = 0;
    int n_fail   = 0;

    icache_refill dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .tag_wen(tag_wen), .tag_wdata(tag_wdata),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive point: just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point: well clear of the rising edge.
    task automatic sample();
        #3;
    endtask

    task automatic run_refill(input logic [31:0] addr, input logic [31:0] base,
                              input int ar_wait, input bit bubbles,
                              input int bad_resp_beat, input int bad_last_beat,
                              input int exp_done_cyc);
        int          cyc, beat, k, nfwd;
        logic [2:0]  off, start, bank;
        logic [31:0] exp_araddr;
        logic [1:0]  exp_burst;
        bit          err_exp, fwd_exp;
        off = addr[4:2];
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        start      = off;
        exp_araddr = {addr[31:2], 2'b00};
        exp_burst  = 2'b10;
`else
        start      = 3'd0;
        exp_araddr = {addr[31:5], 5'b0};
        exp_burst  = 2'b01;
`endif
        err_exp = (bad_resp_beat >= 0) || (bad_last_beat >= 0);

        req_valid = 1'b1;
        req_addr  = addr;
        sample();
        check("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        cyc = 1;
        sample();
        check("err_cleared_on_accept", err, 0);
        check("req_ready_busy", req_ready, 0);

        for (int w = 0; w < ar_wait; w++) begin
            arready = 1'b0;
            if (w > 0) sample();
            check("ar_wait_valid", arvalid, 1);
            check("ar_wait_addr", araddr, exp_araddr);
            check("ar_wait_no_write", ram_wen, 0);
            check("ar_wait_rready", rready, 0);
            tick();
            cyc++;
        end
        arready = 1'b1;
        if (ar_wait > 0) sample();
        check("arvalid", arvalid, 1);
        check("araddr", araddr, exp_araddr);
        check("arlen", arlen, 8'd7);
        check("arsize", arsize, 3'd2);
        check("arburst", arburst, exp_burst);
        check("arid", arid, 4'd0);
        tick();
        cyc++;
        arready = 1'b0;

        beat = 0;
        k    = 0;
        nfwd = 0;
        while (beat < 8) begin
            if (k > 40) begin
                check("r_phase_timeout", beat, 8);
                break;
            end
            rvalid = !bubbles || (k % 2 == 0);
            rdata  = base + 32'(beat);
            rresp  = (beat == bad_resp_beat) ? 2'b10 : 2'b00;
            rlast  = ((beat == 7) != (beat == bad_last_beat));
            sample();
            check("rready", rready, 1);
            check("done_early", done, 0);
            if (rvalid) begin
                bank = start + 3'(beat);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                fwd_exp = (beat == 0);
`else
                fwd_exp = (3'(beat) == off);
`endif
                check("ram_wen", ram_wen, 8'b1 << bank);
                check("ram_en", ram_en, 8'b1 << bank);
                check("ram_wdata", ram_wdata, base + 32'(beat));
                check("ram_addr", ram_addr, addr[11:5]);
                check("fwd_valid", fwd_valid, fwd_exp);
                if (fwd_exp) check("fwd_data", fwd_data, base + 32'(beat));
                if (fwd_valid) nfwd++;
            end else begin
                check("bubble_no_write", ram_wen, 0);
                check("bubble_no_fwd", fwd_valid, 0);
            end
            tick();
            cyc++;
            k++;
            if (rvalid) beat++;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;

        sample();
        check("done_cycle", cyc, exp_done_cyc);
        check("done", done, 1);
        check("tag_wen", tag_wen, 1);
        check("tag_wdata", tag_wdata, {~err_exp, addr[31:12]});
        check("err", err, err_exp);
        check("fin_no_write", ram_wen, 0);
        check("fwd_count", nfwd, 1);
        tick();
        sample();
        check("done_one_cycle", done, 0);
        check("tag_wen_one_cycle", tag_wen, 0);
        check("req_ready_after", req_ready, 1);
        check("err_held", err, err_exp);
        tick();
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = '0;
        rlast     = 1'b0;
        tick();
        tick();
        sample();
        check("rst_req_ready", req_ready, 1);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_tag_wen", tag_wen, 0);
        check("rst_tag_wdata", tag_wdata, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        tick();
        resetn = 1'b1;
        tick();

        // Basic line, zero-wait AXI.
        run_refill(32'h1FC0_0024, 32'h0000_00A0, 0, 1'b0, -1, -1, 10);
        // AR stalled for 5 cycles, with offset 7 at the top index.
        run_refill(32'h0000_3FFC, 32'hB000_0000, 5, 1'b0, -1, -1, 15);
        // rvalid toggling 1-0-1-0.
        run_refill(32'h8000_0040, 32'h0000_00C0, 0, 1'b1, -1, -1, 17);
        // SLVERR on beat 3.
        run_refill(32'h1234_5678, 32'h0000_00D0, 0, 1'b0, 3, -1, 10);
        // Early rlast on beat 5. The err from the previous line must clear on accept.
        run_refill(32'hFFFF_FFE0, 32'h0000_00E0, 0, 1'b0, -1, 5, 10);

        // Reset in the middle of a burst, on beat 4.
        req_valid = 1'b1;
        req_addr  = 32'h0000_1004;
        tick();
        req_valid = 1'b0;
        arready   = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1;
            rdata  = 32'h5500_0000 + 32'(b);
            rlast  = 1'b0;
            tick();
        end
        rvalid = 1'b1;
        rdata  = 32'h5500_0004;
        sample();
        check("pre_reset_write", ram_wen != 0, 1);
        resetn = 1'b0;
        #1;
        check("reset_arvalid", arvalid, 0);
        check("reset_rready", rready, 0);
        check("reset_ram_wen", ram_wen, 0);
        check("reset_tag_wen", tag_wen, 0);
        check("reset_fwd", fwd_valid, 0);
        tick();
        rvalid = 1'b0;
        tick();
        resetn = 1'b1;
        sample();
        check("post_reset_req_ready", req_ready, 1);
        check("post_reset_done", done, 0);
        tick();
        run_refill(32'hDEAD_BEE8, 32'h0000_00F0, 0, 1'b0, -1, -1, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
